// File: rtl/exp6_unidade_controle.sv
// Control unit for the play/compare memory game (experiment 6).
// Moore FSM: next state is decoded combinationally, while the state and all
// control outputs are registered together, so the outputs always match the
// current state encoding shown on db_estado.
module exp6_unidade_controle (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada,
    input  logic       igual,
    input  logic       fimE,
    input  logic       fimL,
    input  logic       fimTempo,
    output logic       zeraE,
    output logic       contaE,
    output logic       zeraL,
    output logic       contaL,
    output logic       zeraR,
    output logic       registraR,
    output logic       zeraT,
    output logic       contaT,
    output logic       acertou,
    output logic       errou,
    output logic       timeout,
    output logic       pronto,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        INICIAL        = 4'h0,
        PREPARACAO     = 4'h1,
        INICIO_RODADA  = 4'h2,
        ESPERA_JOGADA  = 4'h3,
        REGISTRA       = 4'h4,
        COMPARACAO     = 4'h5,
        PROXIMO        = 4'h6,
        PROXIMA_RODADA = 4'h7,
        FIM_ACERTOU    = 4'hA,
        FIM_TIMEOUT    = 4'hD,
        FIM_ERROU      = 4'hE
    } estado_t;

    estado_t state_q, state_d;

    // Output word order:
    // {zeraE, contaE, zeraL, contaL, zeraR, registraR, zeraT, contaT,
    //  acertou, errou, timeout, pronto}
    logic [11:0] outs_q;

    function automatic logic [11:0] decode(input estado_t s);
        case (s)
            PREPARACAO:     decode = 12'b1010_1010_0000;
            INICIO_RODADA:  decode = 12'b1000_0010_0000;
            ESPERA_JOGADA:  decode = 12'b0000_0001_0000;
            REGISTRA:       decode = 12'b0000_0100_0000;
            PROXIMO:        decode = 12'b0100_0010_0000;
            PROXIMA_RODADA: decode = 12'b0001_0000_0000;
            FIM_ACERTOU:    decode = 12'b0000_0000_1001;
            FIM_ERROU:      decode = 12'b0000_0000_0101;
            FIM_TIMEOUT:    decode = 12'b0000_0000_0011;
            default:        decode = 12'b0000_0000_0000;
        endcase
    endfunction

    // Next-state logic; a play beats a simultaneous timeout in espera_jogada.
    always_comb begin
        state_d = INICIAL;
        case (state_q)
            INICIAL:        state_d = iniciar ? PREPARACAO : INICIAL;
            PREPARACAO:     state_d = INICIO_RODADA;
            INICIO_RODADA:  state_d = ESPERA_JOGADA;
            ESPERA_JOGADA: begin
                if (jogada)        state_d = REGISTRA;
                else if (fimTempo) state_d = FIM_TIMEOUT;
                else               state_d = ESPERA_JOGADA;
            end
            REGISTRA:       state_d = COMPARACAO;
            COMPARACAO: begin
                if (!igual)     state_d = FIM_ERROU;
                else if (!fimE) state_d = PROXIMO;
                else if (!fimL) state_d = PROXIMA_RODADA;
                else            state_d = FIM_ACERTOU;
            end
            PROXIMO:        state_d = ESPERA_JOGADA;
            PROXIMA_RODADA: state_d = INICIO_RODADA;
            FIM_ACERTOU, FIM_ERROU, FIM_TIMEOUT:
                            state_d = iniciar ? PREPARACAO : state_q;
            default:        state_d = INICIAL;
        endcase
    end

    // State and registered outputs move together; reset clears both at once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= INICIAL;
            outs_q  <= '0;
        end else begin
            state_q <= state_d;
            outs_q  <= decode(state_d);
        end
    end

    assign {zeraE, contaE, zeraL, contaL, zeraR, registraR, zeraT, contaT,
            acertou, errou, timeout, pronto} = outs_q;
    assign db_estado = state_q;

endmodule
